aes_cipher_feeder: RTL

Upstream feeder and result buffer for the `aes_cipher` core; it is the register front-end between the RISC-V core's 32-bit store/load path and the 128-bit cipher.
- Accepts key and plaintext as 32-bit word writes.
- Issues a single-cycle load/start pulse to the cipher with stable 128-bit operands.
- Waits for the cipher's `done`, captures the 128-bit ciphertext and serves it back as 32-bit word reads.
- Exposes busy, result-valid, completion-pulse and (optionally) timeout-error status.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_in_regs.sv | 34 +++
 rtl/aes_cipher_feeder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES cipher feeder: FSM encoding, operand address map, widths.
// Word 0 of every 128-bit block is its most significant word.
package aes_pkg;

  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_BLOCK_W = 128;

  localparam logic [2:0] AES_ADDR_KEY0 = 3'd0;
  localparam logic [2:0] AES_ADDR_TXT0 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } aes_state_e;

  function automatic logic [AES_WORD_W-1:0] aes_word_sel(
    input logic [AES_BLOCK_W-1:0] blk,
    input logic [1:0]             idx
  );
    logic [AES_WORD_W-1:0] w;
    w = blk[127:96];
    case (idx)
      2'd0: w = blk[127:96];
      2'd1: w = blk[95:64];
      2'd2: w = blk[63:32];
      2'd3: w = blk[31:0];
      default: w = blk[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_in_regs.sv
// Write-only 8x32 operand register file (4 key words, 4 text words), frozen while busy.
// Presents the key and text as packed 128-bit blocks, word 0 in the top bits.
module aes_in_regs
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   busy,
  input  logic [2:0]             wr_addr,
  input  logic [AES_WORD_W-1:0]  wr_data,
  output logic [AES_BLOCK_W-1:0] key,
  output logic [AES_BLOCK_W-1:0] text
);

  logic [AES_WORD_W-1:0] key_w [4];
  logic [AES_WORD_W-1:0] txt_w [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        key_w[i] <= '0;
        txt_w[i] <= '0;
      end
    end else if (wr_en && !busy) begin
      if (wr_addr >= AES_ADDR_TXT0) txt_w[wr_addr[1:0]] <= wr_data;
      else                          key_w[wr_addr[1:0]] <= wr_data;
    end
  end

  assign key  = {key_w[0], key_w[1], key_w[2], key_w[3]};
  assign text = {txt_w[0], txt_w[1], txt_w[2], txt_w[3]};

endmodule

// File: rtl/aes_cipher_feeder.sv
// Register front-end between a 32-bit load/store path and the 128-bit aes_cipher core.
// Optional RUN timeout is built only when AES_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | operands writable, waiting for start
// LOAD  | cipher_ld asserted for one cycle, operands frozen
// RUN   | waiting for cipher_done (or timeout)
module aes_cipher_feeder
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [AES_WORD_W-1:0]  wr_data,
  input  logic                   start,
  input  logic [1:0]             rd_addr,
  output logic [AES_WORD_W-1:0]  rd_data,
  output logic                   busy,
  output logic                   res_valid,
  output logic                   done_pulse,
  output logic                   err,
  output logic                   cipher_ld,
  output logic [AES_BLOCK_W-1:0] cipher_key,
  output logic [AES_BLOCK_W-1:0] cipher_text,
  input  logic                   cipher_done,
  input  logic [AES_BLOCK_W-1:0] cipher_out
);

  aes_state_e             state;
  logic [AES_BLOCK_W-1:0] result;

  aes_in_regs u_in_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .busy    (busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .key     (cipher_key),
    .text    (cipher_text)
  );

`ifdef AES_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             timeout_hit;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC));
  assign err = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      result     <= '0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      done_pulse <= 1'b0;
      cipher_ld  <= 1'b0;
`ifdef AES_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_pulse <= 1'b0;
      cipher_ld  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD;
            busy      <= 1'b1;
            cipher_ld <= 1'b1;
            res_valid <= 1'b0;
`ifdef AES_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          state <= ST_RUN;
`ifdef AES_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_RUN: begin
          // a done arriving on the terminal-count cycle still counts as success
          if (cipher_done) begin
            result     <= cipher_out;
            res_valid  <= 1'b1;
            done_pulse <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
`ifdef AES_TIMEOUT_EN
          else if (timeout_hit) begin
            err_q <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data = aes_word_sel(result, rd_addr);

endmodule
